amount_ascii_converter: RTL

Sequential binary-to-ASCII stage between the four coin counters and the UART report FSM. On a conversion request it snapshots all four 8-bit amounts and converts each to three ASCII decimal digits using iterative double-dabble, one channel at a time. It then presents all four 24-bit fields atomically and pulses snap_valid, which drives the UART FSM's start_sending. It replaces the per-channel combinational converters, so the transmitter never sees a half-updated set of amounts.

---
 rtl/piggy_pkg.sv | 37 +++
 rtl/amount_ascii_converter_dabble_step.sv | 25 ++
 rtl/amount_ascii_converter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/piggy_pkg.sv
// Shared types and constants for the coin-amount reporting path.
// Holds the converter state encoding and the BCD-to-ASCII formatting helper.
package piggy_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam int NUM_CH    = 4;
  localparam int BIN_W     = 8;
  localparam int BCD_W     = 12;
  localparam int SHIFT_CNT = 8;
  localparam int SCR_W     = BCD_W + BIN_W;

  // Units digit is always printed; tens only blanks when hundreds is blank too.
  function automatic logic [23:0] format_bcd(input logic [11:0] bcd, input logic zero_blank);
    logic       blank_h;
    logic       blank_t;
    logic [7:0] hund;
    logic [7:0] tens;
    logic [7:0] unit;
    blank_h = zero_blank && (bcd[11:8] == 4'h0);
    blank_t = blank_h && (bcd[7:4] == 4'h0);
    hund    = blank_h ? ASCII_SPACE : (ASCII_ZERO | {4'h0, bcd[11:8]});
    tens    = blank_t ? ASCII_SPACE : (ASCII_ZERO | {4'h0, bcd[7:4]});
    unit    = ASCII_ZERO | {4'h0, bcd[3:0]};
    return {hund, tens, unit};
  endfunction

endpackage

// File: rtl/amount_ascii_converter_dabble_step.sv
// One double-dabble iteration on the 20-bit scratch: add 3 to every BCD
// nibble that is >= 5, then shift the whole word left by one.
module dabble_step
  import piggy_pkg::*;
(
  input  logic [SCR_W-1:0] scratch_in,
  output logic [SCR_W-1:0] scratch_out
);

  logic [SCR_W-1:0] adj_s;

  // Correct each BCD nibble before the shift so it never exceeds 9 afterwards.
  always_comb begin
    adj_s = scratch_in;
    for (int n = 0; n < 3; n++) begin
      if (scratch_in[BIN_W + 4*n +: 4] >= 4'd5) begin
        adj_s[BIN_W + 4*n +: 4] = scratch_in[BIN_W + 4*n +: 4] + 4'd3;
      end else begin
        adj_s[BIN_W + 4*n +: 4] = scratch_in[BIN_W + 4*n +: 4];
      end
    end
    scratch_out = {adj_s[SCR_W-2:0], 1'b0};
  end

endmodule

// File: rtl/amount_ascii_converter.sv
// Snapshots four coin amounts, converts them one at a time to 3-digit ASCII,
// and publishes all four fields together with a one-cycle snap_valid.
module amount_ascii_converter
  import piggy_pkg::*;
#(
  parameter bit ZERO_BLANK = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  amount0,
  input  logic [7:0]  amount1,
  input  logic [7:0]  amount2,
  input  logic [7:0]  amount3,
  input  logic        conv_req,
  output logic [23:0] ascii0,
  output logic [23:0] ascii1,
  output logic [23:0] ascii2,
  output logic [23:0] ascii3,
  output logic        busy,
  output logic        snap_valid
);

  localparam logic [23:0] ASCII_RST = format_bcd(12'h000, ZERO_BLANK);
  localparam logic [3:0]  CNT_LAST  = 4'(SHIFT_CNT - 1);

  state_e             state_r;
  state_e             state_s;
  logic [1:0]         idx_r;
  logic [3:0]         cnt_r;
  logic               pending_r;
  logic               capture_s;
  logic [SCR_W-1:0]   scratch_r;
  logic [SCR_W-1:0]   step_s;
  logic [23:0]        fmt_s;
  logic [BIN_W-1:0]   amount_s [NUM_CH];
  logic [BIN_W-1:0]   snap_r   [NUM_CH];
  logic [23:0]        shadow_r [NUM_CH];
  logic [23:0]        ascii_r  [NUM_CH];
  logic               busy_r;
  logic               snap_valid_r;

  dabble_step u_step (
    .scratch_in  (scratch_r),
    .scratch_out (step_s)
  );

  assign fmt_s = format_bcd(scratch_r[SCR_W-1:BIN_W], ZERO_BLANK);

  // Gather the counter inputs into an indexable array.
  always_comb begin
    amount_s[0] = amount0;
    amount_s[1] = amount1;
    amount_s[2] = amount2;
    amount_s[3] = amount3;
  end

  // Next-state logic; DONE doubles as the capture cycle for a queued re-run.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (conv_req) begin
          state_s   = LOAD;
          capture_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD:  state_s = SHIFT;
      SHIFT: begin
        if (cnt_r == CNT_LAST) state_s = STORE;
        else                   state_s = SHIFT;
      end
      STORE: begin
        if (idx_r == 2'd3) state_s = DONE;
        else               state_s = LOAD;
      end
      DONE: begin
        if (pending_r || conv_req) begin
          state_s   = LOAD;
          capture_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Control registers: state, channel index, request queueing, status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= 2'd0;
      pending_r    <= 1'b0;
      busy_r       <= 1'b0;
      snap_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      busy_r       <= (state_s != IDLE);
      snap_valid_r <= (state_s == DONE);
      if (capture_s) begin
        idx_r <= 2'd0;
      end else if (state_r == STORE && idx_r != 2'd3) begin
        idx_r <= idx_r + 2'd1;
      end
      if (capture_s) begin
        pending_r <= 1'b0;
      end else if (conv_req && (state_r == LOAD || state_r == SHIFT || state_r == STORE)) begin
        pending_r <= 1'b1;
      end
    end
  end

  // Datapath: snapshot, dabble scratch, per-channel shadow, published fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= 4'd0;
      scratch_r <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        snap_r[c]   <= '0;
        shadow_r[c] <= ASCII_RST;
        ascii_r[c]  <= ASCII_RST;
      end
    end else begin
      if (capture_s) begin
        for (int c = 0; c < NUM_CH; c++) snap_r[c] <= amount_s[c];
      end
      case (state_r)
        LOAD: begin
          scratch_r <= {12'h000, snap_r[idx_r]};
          cnt_r     <= 4'd0;
        end
        SHIFT: begin
          scratch_r <= step_s;
          cnt_r     <= cnt_r + 4'd1;
        end
        STORE: begin
          shadow_r[idx_r] <= fmt_s;
          if (idx_r == 2'd3) begin
            for (int c = 0; c < NUM_CH - 1; c++) ascii_r[c] <= shadow_r[c];
            ascii_r[NUM_CH-1] <= fmt_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign ascii0     = ascii_r[0];
  assign ascii1     = ascii_r[1];
  assign ascii2     = ascii_r[2];
  assign ascii3     = ascii_r[3];
  assign busy       = busy_r;
  assign snap_valid = snap_valid_r;

endmodule
